// File: rtl/alsu_result_select_pipe.sv
// Registered 8-way ALSU result selector with a valid/ready output stage,
// illegal-opcode flagging and a saturating illegal-opcode counter.
module alsu_result_select_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [3:0]       out_sel,
  output logic             out_zero,
  output logic             out_illegal,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] src;
  logic             legal;
  logic             accept;

  logic [WIDTH-1:0] out_p0;
  logic [3:0]       sel_p0;
  logic             zero_p0;
  logic             illegal_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] cnt_p0;

  always_comb begin
    src   = '0;
    legal = 1'b1;
    case (Sel)
      4'b0000, 4'b0001: src = A;
      4'b0010:          src = B;
      4'b0110:          src = C;
      4'b1010:          src = D;
      4'b0101, 4'b0111: src = E;
      4'b1000:          src = F;
      4'b1110:          src = G;
      4'b1100:          src = H;
      default:          legal = 1'b0;
    endcase
  end

  // Single output register, no skid entry: accept only when it is empty or draining.
  assign in_ready = !vld_p0 || out_ready;
  assign accept   = in_valid && in_ready;

  // ---- stage p0: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p0     <= '0;
      sel_p0     <= '0;
      zero_p0    <= 1'b0;
      illegal_p0 <= 1'b0;
      vld_p0     <= 1'b0;
      cnt_p0     <= '0;
    end else begin
      if (accept) begin
        vld_p0     <= 1'b1;
        sel_p0     <= Sel;
        illegal_p0 <= !legal;
        // Illegal opcodes keep the previous data so the result still flows downstream.
        if (legal) begin
          out_p0  <= src;
          zero_p0 <= (src == '0);
        end
      end else if (out_ready) begin
        vld_p0 <= 1'b0;
      end

      if (clr_cnt)
        cnt_p0 <= '0;
      else if (accept && !legal)
        cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  assign out_valid   = vld_p0;
  assign Out         = out_p0;
  assign out_sel     = sel_p0;
  assign out_zero    = zero_p0;
  assign out_illegal = illegal_p0;
  assign illegal_cnt = cnt_p0;

endmodule

// File: doc/alsu_result_select_pipe.md
Name: alsu_result_select_pipe

Overview:
- Parametrised, registered successor to the ALSU's 8-way result selector.
- Decodes the 4-bit operation select, picks one of eight functional-unit results of WIDTH bits, and registers it behind a valid/ready handshake.
- Flags illegal opcodes instead of latching silently, and keeps a saturating illegal-opcode counter.
- Sits between the ALSU functional units (adder, logic, shifters, etc.) and the ALSU output/flag logic.

Parameters:
- WIDTH, 4, data width of every source bus and of the result.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  source buses and Sel are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- Sel  input  4  ALSU operation select.
- A, B, C, D, E, F, G, H  input  WIDTH each  functional-unit results, sources 0..7.
- out_valid  output  1  registered result is valid.
- out_ready  input  1  downstream accepts the result this cycle.
- Out  output  WIDTH  registered selected result.
- out_sel  output  4  Sel value that produced Out.
- out_zero  output  1  Out == 0 for this result.
- out_illegal  output  1  this result came from an illegal Sel.
- clr_cnt  input  1  synchronous clear of illegal_cnt.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal opcodes.

Behaviour:
- All state is updated on the rising edge of clk only. rst is sampled synchronously and overrides every other input.
- Reset values:
  - Out = 0, out_sel = 0, out_zero = 0.
  - out_valid = 0, out_illegal = 0, illegal_cnt = 0.
- in_ready is combinational: in_ready = !out_valid || out_ready. The block is a single output register with no skid entry.
- Accept = in_valid && in_ready. Latency from accept to out_valid is exactly 1 cycle. Full throughput (one result per cycle) is sustained while out_ready = 1.
- Decode map (Sel -> source):
  - 0000, 0001 -> A
  - 0010 -> B
  - 0110 -> C
  - 1010 -> D
  - 0101, 0111 -> E
  - 1000 -> F
  - 1110 -> G
  - 1100 -> H
  - Every other Sel (0011, 0100, 1001, 1011, 1101, 1111) is illegal.
- On accept with a legal Sel:
  - Out <= selected source; out_sel <= Sel; out_zero <= (selected source == 0).
  - out_illegal <= 0; out_valid <= 1.
- On accept with an illegal Sel:
  - Out holds its previous value and out_zero holds its previous value.
  - out_sel <= Sel; out_illegal <= 1; out_valid <= 1 (the result is still presented so the pipeline never stalls).
  - illegal_cnt increments by 1, saturating at 2^CNT_W - 1 with no wrap.
- No accept and out_ready = 1: out_valid <= 0. Out, out_sel, out_zero and out_illegal hold.
- No accept and out_ready = 0: all outputs hold (stall). Out must stay stable while out_valid = 1 and out_ready = 0.
- Same-cycle accept and drain (out_valid = 1, out_ready = 1, in_valid = 1): the old result is consumed and the new one is loaded in the same edge. out_valid stays 1.
- clr_cnt = 1: illegal_cnt <= 0. clr_cnt has priority over a simultaneous illegal accept, so the counter reads 0 afterwards. clr_cnt does not affect the data path.
- rst asserted mid-stall or mid-stream: the in-flight result is discarded, out_valid = 0 next cycle, and in_ready = 1 immediately after reset.
- Sources and Sel are sampled only on accept. Changes on those inputs while in_ready = 0 have no effect.
- The fully combinational output of the predecessor is not preserved. Consumers must qualify Out with out_valid.

Test Plan:
- Reset, then for each legal Sel drive A..H = 1..8 with out_ready = 1:
  - Out equals the mapped value 1 cycle after accept (e.g. Sel = 0111 -> Out = 5, Sel = 1100 -> Out = 8).
  - out_illegal = 0; out_zero = 0.
- Load Sel = 0010 with B = 9, then Sel = 0011:
  - Second result has Out = 9 (held), out_illegal = 1, out_sel = 0011, illegal_cnt = 1.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 and changing inputs:
  - in_ready = 0 throughout; Out stable.
  - On out_ready = 1, the next accept occurs in the same cycle as the drain and out_valid stays 1.
- Streaming 16 legal ops with out_ready = 1: one result per cycle, order preserved, no bubbles.
- Counter behaviour with CNT_W = 2:
  - 5 illegal accepts -> illegal_cnt = 3 (saturated).
  - clr_cnt together with an illegal accept -> illegal_cnt = 0.
- Data-dependent flags and reset:
  - Sel = 1000 with F = 0 -> out_zero = 1.
  - Assert rst while stalled -> out_valid = 0, Out = 0, illegal_cnt = 0 on the next cycle.
